// File: rtl/ita_output_buffer_if.sv
// ---------------------------------------------------------------------------
// ita_output_buffer_if
//
// Purpose:
//    Groups the push side (result beats from the ITA datapath) and the
//    output stream side of ita_output_buffer into one bundle.
//
// Signals (named as seen from the buffer):
//    push_valid_i  : result beat valid
//    push_ready_o  : buffer has space
//    push_data_i   : N*DW-bit result beat
//    push_step_i   : step tag of the pushed beat (controller step encoding)
//    oup_valid_o   : output beat valid
//    oup_ready_i   : consumer ready
//    oup_data_o    : N*DW-bit output beat
//    oup_step_o    : step tag of the output beat
//    oup_last_o    : output beat is the last beat of its tile
//
// Modports:
//    slave  : the buffer itself
//    master : the environment (producer + consumer)
// ---------------------------------------------------------------------------
interface ita_output_buffer_if #(
   parameter int N      = 16,
   parameter int DW     = 8,
   parameter int STEP_W = 4
);
   logic                push_valid_i;
   logic                push_ready_o;
   logic [N*DW-1:0]     push_data_i;
   logic [STEP_W-1:0]   push_step_i;
   logic                oup_valid_o;
   logic                oup_ready_i;
   logic [N*DW-1:0]     oup_data_o;
   logic [STEP_W-1:0]   oup_step_o;
   logic                oup_last_o;

   modport slave (
      input  push_valid_i,
      output push_ready_o,
      input  push_data_i,
      input  push_step_i,
      output oup_valid_o,
      input  oup_ready_i,
      output oup_data_o,
      output oup_step_o,
      output oup_last_o
   );

   modport master (
      output push_valid_i,
      input  push_ready_o,
      output push_data_i,
      output push_step_i,
      input  oup_valid_o,
      output oup_ready_i,
      input  oup_data_o,
      input  oup_step_o,
      input  oup_last_o
   );
endinterface

// File: rtl/ita_output_buffer.sv
// ---------------------------------------------------------------------------
// ita_output_buffer
//
// Purpose:
//    Output buffer behind the ITA datapath. Stores up to DEPTH requantized
//    N-lane result beats in a circular buffer and drains them over a
//    valid/ready stream. Each output beat carries its step tag, the last
//    beat of every M*M tile is flagged, and a one-cycle tile-done pulse
//    follows the pop of that beat. The controller throttles inner-tile work
//    by counting the push/pop handshakes against the same DEPTH.
//
// Ports:
//    clk_i        : clock
//    rst_ni       : asynchronous active-low reset
//    clear_i      : synchronous flush (wins over push and pop)
//    bus          : ita_output_buffer_if.slave (push + output stream)
//    tile_done_o  : registered pulse, cycle after the tile's last beat pops
//    count_o      : occupied entries (0..DEPTH)
//    overflow_o   : sticky, push attempted while full
//
// Configuration:
//    ITA_OUTBUF_BYPASS_EN : when defined, a beat pushed into an empty buffer
//                           is presented on the output in the same cycle and,
//                           if taken immediately, never stored.
// ---------------------------------------------------------------------------
module ita_output_buffer #(
   parameter int N      = 16,
   parameter int M      = 64,
   parameter int DW     = 8,
   parameter int DEPTH  = 4,
   parameter int STEP_W = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   ita_output_buffer_if.slave          bus,
   output logic                        tile_done_o,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic                        overflow_o
);

   localparam int BEATS = (M * M) / N;
   localparam int AW    = $clog2(DEPTH);
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [BCW-1:0] LAST_BC  = BCW'(BEATS - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [AW-1:0]     wp_q, wp_d;
   logic [AW-1:0]     rp_q, rp_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [BCW-1:0]    bc_q, bc_d;
   logic              tile_done_q, tile_done_d;
   logic              overflow_q, overflow_d;

   // Beat storage; read asynchronously at rp so that a beat written at an
   // edge is visible on the output right after that edge.
   logic [N*DW-1:0]   mem_data_q [DEPTH];
   logic [STEP_W-1:0] mem_step_q [DEPTH];

   // ------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------
   logic full;
   logic empty;
   logic bypass_sel;    // output is being fed straight from the push inputs
   logic bypass_take;   // bypassed beat consumed this cycle, never stored
   logic push_fire;     // beat written into storage
   logic pop_fire;      // output handshake (stored or bypassed beat)
   logic pop_mem;       // output handshake that frees a stored entry
   logic at_last;
   logic oup_valid;

   always_comb begin
      full  = (cnt_q == FULL_CNT);
      empty = (cnt_q == '0);

`ifdef ITA_OUTBUF_BYPASS_EN
      bypass_sel = empty && bus.push_valid_i;
`else
      bypass_sel = 1'b0;
`endif

      oup_valid   = !empty || bypass_sel;
      bypass_take = bypass_sel && bus.oup_ready_i;
      pop_fire    = oup_valid && bus.oup_ready_i;
      pop_mem     = pop_fire && !bypass_take;
      // Ready depends only on occupancy: a full buffer refuses a push even
      // if a pop happens in the same cycle.
      push_fire   = bus.push_valid_i && !full && !bypass_take;
      at_last     = (bc_q == LAST_BC);
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      wp_d        = wp_q;
      rp_d        = rp_q;
      cnt_d       = cnt_q;
      bc_d        = bc_q;
      tile_done_d = 1'b0;
      overflow_d  = overflow_q;

      if (clear_i) begin
         wp_d        = '0;
         rp_d        = '0;
         cnt_d       = '0;
         bc_d        = '0;
         tile_done_d = 1'b0;
         overflow_d  = 1'b0;
      end else begin
         if (push_fire) begin
            wp_d = wp_q + 1'b1;
         end
         if (pop_mem) begin
            rp_d = rp_q + 1'b1;
         end

         unique case ({push_fire, pop_mem})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase

         // Beat counter tracks every accepted output beat, including
         // bypassed ones; BEATS need not be a power of two.
         if (pop_fire) begin
            bc_d        = at_last ? '0 : bc_q + 1'b1;
            tile_done_d = at_last;
         end

         if (bus.push_valid_i && full) begin
            overflow_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         bc_q        <= '0;
         tile_done_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         cnt_q       <= cnt_d;
         bc_q        <= bc_d;
         tile_done_q <= tile_done_d;
         overflow_q  <= overflow_d;
      end
   end

   // ------------------------------------------------------------------
   // Storage (no reset: contents are meaningless while cnt is zero)
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (push_fire && !clear_i) begin
         mem_data_q[wp_q] <= bus.push_data_i;
         mem_step_q[wp_q] <= bus.push_step_i;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.push_ready_o = !full;
   assign bus.oup_valid_o  = oup_valid;
   assign bus.oup_last_o   = oup_valid && at_last;

   always_comb begin
      if (bypass_sel) begin
         bus.oup_data_o = bus.push_data_i;
         bus.oup_step_o = bus.push_step_i;
      end else begin
         bus.oup_data_o = mem_data_q[rp_q];
         bus.oup_step_o = mem_step_q[rp_q];
      end
   end

   assign tile_done_o = tile_done_q;
   assign count_o     = cnt_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ita_output_buffer.sv
module tb_ita_output_buffer;
   localparam int N      = 16;
   localparam int M      = 64;
   localparam int DW     = 8;
   localparam int DEPTH  = 4;
   localparam int STEP_W = 4;
   localparam int W      = N * DW;
   localparam int BEATS  = (M * M) / N;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clear_i = 1'b0;
   logic          tile_done_o;
   logic [CW-1:0] count_o;
   logic          overflow_o;

   always #5 clk = ~clk;

   ita_output_buffer_if #(.N(N), .DW(DW), .STEP_W(STEP_W)) bus ();

   ita_output_buffer #(
      .N(N), .M(M), .DW(DW), .DEPTH(DEPTH), .STEP_W(STEP_W)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .bus         (bus),
      .tile_done_o (tile_done_o),
      .count_o     (count_o),
      .overflow_o  (overflow_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: FIFO of beats, total popped beats since reset/clear
   // ------------------------------------------------------------------
   typedef struct {
      logic [W-1:0]      dat;
      logic [STEP_W-1:0] stp;
   } beat_t;

   beat_t             q[$];
   int                popped;
   logic              m_ovf;
   logic              m_td;
   logic              prev_stall;
   logic [W-1:0]      prev_data;
   int                last_idx[$];
   int                td_cnt;

   task automatic model_reset();
      q.delete();
      popped     = 0;
      m_ovf      = 1'b0;
      m_td       = 1'b0;
      prev_stall = 1'b0;
   endtask

   function automatic logic [W-1:0] mk(input logic [31:0] tag);
      logic [W-1:0] r;
      for (int k = 0; k < W/32; k++) r[k*32 +: 32] = tag;
      return r;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      for (int k = 0; k < W/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock cycle: apply inputs, compare outputs with the model before
   // the edge, advance the model, then move to the next falling edge.
   task automatic run_cycle(input logic clr, input logic pv, input logic [W-1:0] d,
                            input logic [STEP_W-1:0] s, input logic rdy);
      logic              byp, e_valid, e_ready, e_last, pop, take;
      logic [W-1:0]      e_data;
      logic [STEP_W-1:0] e_step;
      clear_i          = clr;
      bus.push_valid_i = pv;
      bus.push_data_i  = d;
      bus.push_step_i  = s;
      bus.oup_ready_i  = rdy;
      #1;
      e_ready = (q.size() != DEPTH);
      byp = 1'b0;
`ifdef ITA_OUTBUF_BYPASS_EN
      byp = (q.size() == 0) && pv;
`endif
      e_valid = (q.size() != 0) || byp;
      e_data  = '0;
      e_step  = '0;
      if (byp) begin
         e_data = d;
         e_step = s;
      end else if (q.size() != 0) begin
         e_data = q[0].dat;
         e_step = q[0].stp;
      end
      e_last = e_valid && ((popped % BEATS) == BEATS - 1);

      chk("push_ready", bus.push_ready_o, e_ready);
      chk("oup_valid", bus.oup_valid_o, e_valid);
      chk("oup_last", bus.oup_last_o, e_last);
      chk("count", count_o, q.size());
      chk("overflow", overflow_o, m_ovf);
      chk("tile_done", tile_done_o, m_td);
      if (e_valid) begin
         chk("oup_data", bus.oup_data_o, e_data);
         chk("oup_step", bus.oup_step_o, e_step);
      end
      if (prev_stall) begin
         chk("hold_valid", bus.oup_valid_o, 1'b1);
         chk("hold_data", bus.oup_data_o, prev_data);
      end
      if (bus.oup_last_o && rdy && e_valid) last_idx.push_back(popped);
      if (tile_done_o) td_cnt++;
      prev_stall = bus.oup_valid_o && !rdy && !clr;
      prev_data  = bus.oup_data_o;

      if (clr) begin
         model_reset();
      end else begin
         pop  = e_valid && rdy;
         take = byp && rdy;
         m_td = pop && ((popped % BEATS) == BEATS - 1);
         if (pop) popped++;
         if (pop && !take) void'(q.pop_front());
         if (pv && e_ready && !take) q.push_back(beat_t'{dat: d, stp: s});
         if (pv && !e_ready) m_ovf = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      clear_i          = 1'b0;
      bus.push_valid_i = 1'b0;
      bus.oup_ready_i  = 1'b0;
      #1;
   endtask

   // ------------------------------------------------------------------
   // Directed table: fill, overflow, drain in order, clear
   // Expected fields describe the state after the row's clock edge.
   // ------------------------------------------------------------------
   typedef struct {
      logic        clr;
      logic        pv;
      logic [31:0] tag;
      logic        rdy;
      int          cnt;
      logic        valid;
      logic        ready;
      logic        ovf;
      logic [31:0] head;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int start;
      logic [W-1:0] d;

      tbl[0] = '{1'b0, 1'b1, 32'hA1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 32'hA1};
      tbl[1] = '{1'b0, 1'b1, 32'hA2, 1'b0, 2, 1'b1, 1'b1, 1'b0, 32'hA1};
      tbl[2] = '{1'b0, 1'b1, 32'hA3, 1'b0, 3, 1'b1, 1'b1, 1'b0, 32'hA1};
      tbl[3] = '{1'b0, 1'b1, 32'hA4, 1'b0, 4, 1'b1, 1'b0, 1'b0, 32'hA1};
      tbl[4] = '{1'b0, 1'b1, 32'hA5, 1'b0, 4, 1'b1, 1'b0, 1'b1, 32'hA1};
      tbl[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 3, 1'b1, 1'b1, 1'b1, 32'hA2};
      tbl[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 2, 1'b1, 1'b1, 1'b1, 32'hA3};
      tbl[7] = '{1'b0, 1'b0, 32'h00, 1'b1, 1, 1'b1, 1'b1, 1'b1, 32'hA4};
      tbl[8] = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 1'b1, 1'b1, 32'h00};
      tbl[9] = '{1'b1, 1'b0, 32'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h00};

      model_reset();
      td_cnt = 0;
      bus.push_valid_i = 1'b0;
      bus.push_data_i  = '0;
      bus.push_step_i  = '0;
      bus.oup_ready_i  = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_push_ready", bus.push_ready_o, 1'b1);
      chk("rst_oup_valid", bus.oup_valid_o, 1'b0);
      chk("rst_oup_last", bus.oup_last_o, 1'b0);
      chk("rst_tile_done", tile_done_o, 1'b0);
      chk("rst_count", count_o, '0);
      chk("rst_overflow", overflow_o, 1'b0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_cycle(tbl[i].clr, tbl[i].pv, mk(tbl[i].tag), tbl[i].tag[STEP_W-1:0], tbl[i].rdy);
         idle();
         chk($sformatf("tbl%0d_count", i), count_o, tbl[i].cnt);
         chk($sformatf("tbl%0d_valid", i), bus.oup_valid_o, tbl[i].valid);
         chk($sformatf("tbl%0d_ready", i), bus.push_ready_o, tbl[i].ready);
         chk($sformatf("tbl%0d_ovf", i), overflow_o, tbl[i].ovf);
         if (tbl[i].valid) chk($sformatf("tbl%0d_head", i), bus.oup_data_o, mk(tbl[i].head));
      end

      // Simultaneous push+pop holding occupancy at 2
      run_cycle(0, 1, rnd(), 4'(1), 0);
      run_cycle(0, 1, rnd(), 4'(2), 0);
      for (int i = 0; i < 10; i++) run_cycle(0, 1, rnd(), 4'($urandom), 1);
      idle();
      chk("pp_count", count_o, 2);

      // Push while full with consumer ready: refused, overflow set
      run_cycle(0, 1, rnd(), 4'(3), 0);
      run_cycle(0, 1, rnd(), 4'(4), 0);
      run_cycle(0, 1, rnd(), 4'(5), 1);
      idle();
      chk("full_pop_count", count_o, 3);
      chk("full_pop_ovf", overflow_o, 1'b1);

      // Clear with count 3, push active, overflow set
      run_cycle(1, 1, rnd(), 4'(6), 0);
      idle();
      chk("clr_count", count_o, 0);
      chk("clr_valid", bus.oup_valid_o, 1'b0);
      chk("clr_ovf", overflow_o, 1'b0);
      run_cycle(0, 0, '0, '0, 1);

      // Push into empty buffer with consumer ready
      d = rnd();
      clear_i = 1'b0;
      bus.push_valid_i = 1'b1;
      bus.push_data_i = d;
      bus.push_step_i = 4'(7);
      bus.oup_ready_i = 1'b1;
      #1;
`ifdef ITA_OUTBUF_BYPASS_EN
      chk("empty_push_same_cycle_valid", bus.oup_valid_o, 1'b1);
`else
      chk("empty_push_same_cycle_valid", bus.oup_valid_o, 1'b0);
`endif
      run_cycle(0, 1, d, 4'(7), 1);
      idle();
`ifdef ITA_OUTBUF_BYPASS_EN
      chk("empty_push_next_count", count_o, 0);
      chk("empty_push_next_valid", bus.oup_valid_o, 1'b0);
`else
      chk("empty_push_next_count", count_o, 1);
      chk("empty_push_next_valid", bus.oup_valid_o, 1'b1);
      chk("empty_push_next_data", bus.oup_data_o, d);
`endif
      run_cycle(0, 0, '0, '0, 1);

      // Stream 512 beats at full throughput: two tiles
      run_cycle(1, 0, '0, '0, 0);
      last_idx.delete();
      td_cnt = 0;
      for (int i = 0; i < 512; i++) run_cycle(0, 1, rnd(), 4'($urandom), 1);
      for (int i = 0; i < 3; i++) run_cycle(0, 0, '0, '0, 1);
      chk("stream_last_count", last_idx.size(), 2);
      if (last_idx.size() == 2) begin
         chk("stream_last0_idx", last_idx[0], 255);
         chk("stream_last1_idx", last_idx[1], 511);
      end
      chk("stream_tile_done_count", td_cnt, 2);

      // Random traffic with 50% backpressure, 1000 beats
      start = popped;
      for (int c = 0; c < 20000 && (popped - start) < 1000; c++) begin
         run_cycle(0, ($urandom_range(0, 9) < 7), rnd(), 4'($urandom), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a cycle
      run_cycle(0, 1, rnd(), 4'(1), 0);
      run_cycle(0, 1, rnd(), 4'(2), 0);
      idle();
      #1;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_count", count_o, 0);
      chk("async_rst_valid", bus.oup_valid_o, 1'b0);
      chk("async_rst_ready", bus.push_ready_o, 1'b1);
      model_reset();
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) run_cycle(0, 1, rnd(), 4'($urandom), 1);
      run_cycle(0, 0, '0, '0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
